// File: rtl/ebpc_decoder_arbiter_if.sv
// Client-side and decoder-side stream bundle for ebpc_decoder_arbiter.
// The arbiter takes the slave view; the surrounding clients/decoder environment takes the master view.
interface ebpc_decoder_arbiter_if #(
  parameter int NUM_CLIENTS   = 4,
  parameter int DATA_W        = 8,
  parameter int LOG_MAX_WORDS = 24
);
  logic [NUM_CLIENTS*LOG_MAX_WORDS-1:0] cl_num_words_i;
  logic [NUM_CLIENTS-1:0]               cl_num_words_vld_i;
  logic [NUM_CLIENTS-1:0]               cl_num_words_rdy_o;
  logic [NUM_CLIENTS*DATA_W-1:0]        cl_bpc_i;
  logic [NUM_CLIENTS-1:0]               cl_bpc_vld_i;
  logic [NUM_CLIENTS-1:0]               cl_bpc_rdy_o;
  logic [NUM_CLIENTS*DATA_W-1:0]        cl_znz_i;
  logic [NUM_CLIENTS-1:0]               cl_znz_vld_i;
  logic [NUM_CLIENTS-1:0]               cl_znz_rdy_o;
  logic [NUM_CLIENTS*DATA_W-1:0]        cl_data_o;
  logic [NUM_CLIENTS-1:0]               cl_vld_o;
  logic [NUM_CLIENTS-1:0]               cl_last_o;
  logic [NUM_CLIENTS-1:0]               cl_rdy_i;
  logic [LOG_MAX_WORDS-1:0]             dec_num_words_o;
  logic                                 dec_num_words_vld_o;
  logic                                 dec_num_words_rdy_i;
  logic [DATA_W-1:0]                    dec_bpc_o;
  logic                                 dec_bpc_vld_o;
  logic                                 dec_bpc_rdy_i;
  logic [DATA_W-1:0]                    dec_znz_o;
  logic                                 dec_znz_vld_o;
  logic                                 dec_znz_rdy_i;
  logic [DATA_W-1:0]                    dec_data_i;
  logic                                 dec_vld_i;
  logic                                 dec_last_i;
  logic                                 dec_rdy_o;

  modport slave (
    input  cl_num_words_i, cl_num_words_vld_i, cl_bpc_i, cl_bpc_vld_i,
    input  cl_znz_i, cl_znz_vld_i, cl_rdy_i,
    input  dec_num_words_rdy_i, dec_bpc_rdy_i, dec_znz_rdy_i,
    input  dec_data_i, dec_vld_i, dec_last_i,
    output cl_num_words_rdy_o, cl_bpc_rdy_o, cl_znz_rdy_o,
    output cl_data_o, cl_vld_o, cl_last_o,
    output dec_num_words_o, dec_num_words_vld_o, dec_bpc_o, dec_bpc_vld_o,
    output dec_znz_o, dec_znz_vld_o, dec_rdy_o
  );

  modport master (
    output cl_num_words_i, cl_num_words_vld_i, cl_bpc_i, cl_bpc_vld_i,
    output cl_znz_i, cl_znz_vld_i, cl_rdy_i,
    output dec_num_words_rdy_i, dec_bpc_rdy_i, dec_znz_rdy_i,
    output dec_data_i, dec_vld_i, dec_last_i,
    input  cl_num_words_rdy_o, cl_bpc_rdy_o, cl_znz_rdy_o,
    input  cl_data_o, cl_vld_o, cl_last_o,
    input  dec_num_words_o, dec_num_words_vld_o, dec_bpc_o, dec_bpc_vld_o,
    input  dec_znz_o, dec_znz_vld_o, dec_rdy_o
  );
endinterface

// File: rtl/ebpc_decoder_arbiter.sv
// Round-robin arbiter sharing one ebpc_decoder among NUM_CLIENTS requesters; grant held until the last output beat.
// Optional per-client saturating job counters on job_cnt_o when EBPC_ARB_JOB_CNT_EN is defined.
module ebpc_decoder_arbiter #(
  parameter int NUM_CLIENTS   = 4,
  parameter int DATA_W        = 8,
  parameter int LOG_MAX_WORDS = 24,
  localparam int CLIENT_W     = $clog2(NUM_CLIENTS)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  ebpc_decoder_arbiter_if.slave         bus,
  output logic                          busy_o,
`ifdef EBPC_ARB_JOB_CNT_EN
  output logic [NUM_CLIENTS*16-1:0]     job_cnt_o,
`endif
  output logic [CLIENT_W-1:0]           grant_o
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CLIENT_W-1:0] r_grant;
  logic [CLIENT_W-1:0] r_rr_ptr;
  logic                r_nw_done;
  logic [CLIENT_W-1:0] w_sel;
  logic [CLIENT_W-1:0] w_idx;
  logic                w_req_any;
  logic                w_busy;
  logic                w_dec_rdy;
  logic                w_nw_hs;
  logic                w_done;

  // Sum of pointer and offset never reaches 2*NUM_CLIENTS, so a single subtract wraps it.
  function automatic logic [CLIENT_W-1:0] wrap_idx(input logic [CLIENT_W:0] v);
    if (v >= (CLIENT_W+1)'(NUM_CLIENTS)) begin
      return CLIENT_W'(v - (CLIENT_W+1)'(NUM_CLIENTS));
    end else begin
      return v[CLIENT_W-1:0];
    end
  endfunction

  assign w_busy  = (r_state == ST_BUSY);
  assign w_nw_hs = w_busy & ~r_nw_done & bus.cl_num_words_vld_i[r_grant] & bus.dec_num_words_rdy_i;
  assign w_done  = w_busy & bus.dec_vld_i & w_dec_rdy & bus.dec_last_i;
  assign busy_o  = w_busy;
  assign grant_o = r_grant;

  // Round-robin pick: scan downward so the closest requester at or after r_rr_ptr wins.
  always_comb begin
    w_req_any = 1'b0;
    w_sel     = '0;
    w_idx     = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      w_idx     = wrap_idx({1'b0, r_rr_ptr} + (CLIENT_W+1)'(i));
      w_sel     = bus.cl_num_words_vld_i[w_idx] ? w_idx : w_sel;
      w_req_any = w_req_any | bus.cl_num_words_vld_i[w_idx];
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_req_any ? ST_BUSY : ST_IDLE;
      ST_BUSY: w_state_nxt = w_done ? ST_IDLE : ST_BUSY;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant, round-robin pointer and one-token-per-job tracking
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_nw_done <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_req_any) begin
      r_grant   <= w_sel;
      r_nw_done <= 1'b0;
    end else if (w_done) begin
      r_rr_ptr  <= wrap_idx({1'b0, r_grant} + (CLIENT_W+1)'(1));
      r_nw_done <= 1'b0;
    end else if (w_nw_hs) begin
      r_nw_done <= 1'b1;
    end
  end

  // Stream steering: everything idles at zero unless a grant is held.
  always_comb begin
    bus.cl_num_words_rdy_o  = '0;
    bus.cl_bpc_rdy_o        = '0;
    bus.cl_znz_rdy_o        = '0;
    bus.cl_data_o           = '0;
    bus.cl_vld_o            = '0;
    bus.cl_last_o           = '0;
    bus.dec_num_words_o     = '0;
    bus.dec_num_words_vld_o = 1'b0;
    bus.dec_bpc_o           = '0;
    bus.dec_bpc_vld_o       = 1'b0;
    bus.dec_znz_o           = '0;
    bus.dec_znz_vld_o       = 1'b0;
    w_dec_rdy               = 1'b0;
    if (w_busy) begin
      bus.dec_num_words_o     = bus.cl_num_words_i[int'(r_grant)*LOG_MAX_WORDS +: LOG_MAX_WORDS];
      bus.dec_num_words_vld_o = ~r_nw_done & bus.cl_num_words_vld_i[r_grant];
      bus.cl_num_words_rdy_o[r_grant] = ~r_nw_done & bus.dec_num_words_rdy_i;
      bus.dec_bpc_o           = bus.cl_bpc_i[int'(r_grant)*DATA_W +: DATA_W];
      bus.dec_bpc_vld_o       = bus.cl_bpc_vld_i[r_grant];
      bus.cl_bpc_rdy_o[r_grant] = bus.dec_bpc_rdy_i;
      bus.dec_znz_o           = bus.cl_znz_i[int'(r_grant)*DATA_W +: DATA_W];
      bus.dec_znz_vld_o       = bus.cl_znz_vld_i[r_grant];
      bus.cl_znz_rdy_o[r_grant] = bus.dec_znz_rdy_i;
      bus.cl_data_o[int'(r_grant)*DATA_W +: DATA_W] = bus.dec_data_i;
      bus.cl_vld_o[r_grant]   = bus.dec_vld_i;
      bus.cl_last_o[r_grant]  = bus.dec_last_i;
      w_dec_rdy               = bus.cl_rdy_i[r_grant];
    end else begin
      w_dec_rdy               = 1'b0;
    end
  end

  assign bus.dec_rdy_o = w_dec_rdy;

`ifdef EBPC_ARB_JOB_CNT_EN
  logic [NUM_CLIENTS*16-1:0] r_job_cnt;

  // Per-client completed-job counters, saturating at all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_job_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_CLIENTS; k++) begin
        if (w_done && (r_grant == CLIENT_W'(k)) && (r_job_cnt[k*16 +: 16] != 16'hFFFF)) begin
          r_job_cnt[k*16 +: 16] <= r_job_cnt[k*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign job_cnt_o = r_job_cnt;
`endif

endmodule
